voice_osc_env: RTL and testbench
================================

Name: voice_osc_env

Overview:
- Single-voice signal source for the synth pipeline.
- Combines a period-driven multi-waveform oscillator with a linear ADSR envelope generator.
- A note-on pulse restarts the oscillator phase and starts the attack. A note-off pulse starts the release.
- The downstream pipeline applies velocity, detune mixing and wave selection.

Parameters:
- PERIOD_WIDTH, 22, width of the period input (period is in clock cycles).
- AUDIO_BIT_WIDTH, 16, unsigned sample width.
- ENV_WIDTH, 16, envelope width; full scale is 2^ENV_WIDTH-1.
- RATE_SCALE, 8, clocks per envelope LSB step per unit of (time+1).
- PERIOD_MIN, 2, lower clamp applied to period.

Ports:
- clock_50_000_000  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- note_on  in  1  one-cycle pulse; restarts phase and enters ATTACK.
- note_off  in  1  one-cycle pulse; enters RELEASE.
- period  in  PERIOD_WIDTH  oscillator period in clocks.
- duty_cycle  in  7  pulse-wave high fraction, in units of 1/128.
- attack_time  in  7  attack rate code.
- decay_time  in  7  decay rate code.
- sustain_level  in  7  sustain level code.
- release_time  in  7  release rate code.
- waves  out  3*AUDIO_BIT_WIDTH  packed waveforms: [0] saw, [1] pulse, [2] triangle.
- envelope  out  ENV_WIDTH  current envelope level.
- envelope_end  out  1  high while the envelope is in IDLE.

Behaviour:
- Reset values:
  - phase=0, step=0, latched period=0, divider idle.
  - Envelope state IDLE, envelope=0, envelope_end=1, rate counter=0.
- Oscillator, phase accumulator:
  - 32-bit phase; phase += step every clock, wrapping modulo 2^32.
  - note_on forces phase=0 that cycle; no step is added.
- Oscillator, step computation:
  - Target is step = floor(2^32 / p), where p = max(period, PERIOD_MIN).
  - Computed by a sequential 32-iteration restoring divider.
  - Start condition: divider idle and p differs from the latched period. The divider latches p when it starts.
  - The new step is written 34 clocks after period changes (1 cycle detect/latch, 32 iterations, 1 cycle write). The old step stays in use until then.
  - If period changes while busy, the current division finishes first, then a new one starts.
  - Result is saturated to 2^32-1.
- Oscillator outputs (combinational from the registered phase):
  - saw = phase[31:16].
  - pulse = all-ones when phase[31:25] < duty_cycle, else 0. duty_cycle=0 gives constant 0.
  - triangle = phase[30:15] when phase[31]=0, else the bitwise inverse of phase[30:15].
- Envelope timing:
  - The rate counter counts to (T+1)*RATE_SCALE-1, where T is the active stage's time code.
  - On terminal count it wraps to 0 and the envelope moves 1 LSB.
  - The counter clears on every state change.
- Envelope target: S = {sustain_level, 9'b0}.
- Envelope FSM:
  - IDLE: envelope holds 0; envelope_end=1.
  - ATTACK: increment by 1 per step. At full scale, go to DECAY.
  - DECAY: decrement by 1 per step. When envelope <= S, go to SUSTAIN; if the envelope is already <= S on entry, go at the next clock.
  - SUSTAIN: hold the current level.
  - RELEASE: decrement by 1 per step. At 0, go to IDLE.
- Envelope events:
  - note_on from any state enters ATTACK from the current level; no reset to 0.
  - note_off in ATTACK, DECAY or SUSTAIN enters RELEASE from the current level.
  - note_off in IDLE or RELEASE is ignored.
  - note_on and note_off in the same cycle: note_on wins.
- Other rules:
  - Time, sustain and duty inputs are sampled live each cycle; no latching.
  - Reset asserted mid-operation returns everything to its reset values immediately.
  - The envelope never wraps: it saturates at 0 and at full scale.

Test Plan:
- Reset: assert reset -> waves[0]=0, waves[2]=0, envelope=0, envelope_end=1. With duty_cycle=64, waves[1]=0xFFFF.
- Oscillator, period=1000:
  - 34 clocks after release of reset, step = 4294967.
  - 500 clocks later, saw = floor(500*4294967/65536) = 32767.
  - phase wraps after 1000 clocks.
- Pulse and phase restart:
  - duty_cycle=64, period=1000 -> pulse high for phase[31:25]<64 (~first 500 clocks), then 0.
  - A note_on mid-cycle returns saw to 0 the next clock.
- ADSR, RATE_SCALE=1, all times 0, sustain_level=64:
  - note_on -> envelope reaches 65535 after 65535 clocks.
  - Then decays to 32768 and holds in SUSTAIN.
  - note_off -> reaches 0 after 32768 clocks; envelope_end=1.
- Retrigger: note_on during RELEASE at envelope=1000 -> ATTACK resumes from 1000, not 0.
- Events:
  - note_on and note_off in the same cycle from IDLE -> ATTACK.
  - note_off while IDLE -> no change.
  - attack_time=3 with RATE_SCALE=1 -> one step every 4 clocks.

Source files
------------

// File: rtl/voice_osc_env.sv
// voice_osc_env: single-voice source combining a period-driven phase
// accumulator oscillator (saw / pulse / triangle) with a linear ADSR envelope.
// The oscillator step is floor(2^32 / period), computed by a sequential
// restoring divider so no wide combinational divider is needed.
module voice_osc_env #(
  parameter int PERIOD_WIDTH    = 22,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int ENV_WIDTH       = 16,
  parameter int RATE_SCALE      = 8,
  parameter int PERIOD_MIN      = 2
) (
  input  logic                         clock_50_000_000,
  input  logic                         reset,
  input  logic                         note_on,
  input  logic                         note_off,
  input  logic [PERIOD_WIDTH-1:0]      period,
  input  logic [6:0]                   duty_cycle,
  input  logic [6:0]                   attack_time,
  input  logic [6:0]                   decay_time,
  input  logic [6:0]                   sustain_level,
  input  logic [6:0]                   release_time,
  output logic [3*AUDIO_BIT_WIDTH-1:0] waves,
  output logic [ENV_WIDTH-1:0]         envelope,
  output logic                         envelope_end
);

  // ------------------------------------------------------------------
  // Oscillator: period clamp, step divider, phase accumulator
  // ------------------------------------------------------------------
  localparam logic [PERIOD_WIDTH-1:0] PMIN = PERIOD_WIDTH'(PERIOD_MIN);

  logic [PERIOD_WIDTH-1:0] p_eff;

  logic [PERIOD_WIDTH-1:0] per_lat_q, per_lat_d;
  logic                    div_busy_q, div_busy_d;
  logic                    div_wr_q, div_wr_d;
  logic [4:0]              div_cnt_q, div_cnt_d;
  logic [PERIOD_WIDTH-1:0] div_rem_q, div_rem_d;
  logic [31:0]             div_quot_q, div_quot_d;
  logic [PERIOD_WIDTH:0]   rem_shift;
  logic [31:0]             step_q, step_d;
  logic [31:0]             phase_q, phase_d;

  // Divider control: latch a new period when idle, run 32 restoring
  // iterations, then publish the quotient as the new step.
  always_comb begin
    p_eff      = (period < PMIN) ? PMIN : period;
    per_lat_d  = per_lat_q;
    div_busy_d = div_busy_q;
    div_wr_d   = div_wr_q;
    div_cnt_d  = div_cnt_q;
    div_rem_d  = div_rem_q;
    div_quot_d = div_quot_q;
    step_d     = step_q;
    // The remainder is always below the divisor, so its doubled value
    // fits in one extra bit.
    rem_shift  = {div_rem_q, 1'b0};
    if (div_busy_q) begin
      if (rem_shift >= {1'b0, per_lat_q}) begin
        div_rem_d  = PERIOD_WIDTH'(rem_shift - {1'b0, per_lat_q});
        div_quot_d = {div_quot_q[30:0], 1'b1};
      end else begin
        div_rem_d  = rem_shift[PERIOD_WIDTH-1:0];
        div_quot_d = {div_quot_q[30:0], 1'b0};
      end
      div_cnt_d = div_cnt_q + 5'd1;
      if (div_cnt_q == 5'd31) begin
        div_busy_d = 1'b0;
        div_wr_d   = 1'b1;
      end
    end else if (div_wr_q) begin
      div_wr_d = 1'b0;
      // A divisor of 0 or 1 would need a 33-bit quotient: saturate.
      step_d   = (per_lat_q <= PERIOD_WIDTH'(1)) ? 32'hFFFF_FFFF : div_quot_q;
    end else if (p_eff != per_lat_q) begin
      // The dividend 2^32 has a single leading one; for divisors >= 2 that
      // bit yields a zero quotient bit, so it is pre-loaded as remainder 1
      // and only the 32 trailing zero bits are iterated.
      per_lat_d  = p_eff;
      div_rem_d  = PERIOD_WIDTH'(1);
      div_quot_d = 32'd0;
      div_cnt_d  = 5'd0;
      div_busy_d = 1'b1;
    end
  end

  // Phase accumulator: wraps modulo 2^32, note_on restarts at zero.
  always_comb begin
    phase_d = note_on ? 32'd0 : phase_q + step_q;
  end

  // Oscillator state registers.
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      per_lat_q  <= '0;
      div_busy_q <= 1'b0;
      div_wr_q   <= 1'b0;
      div_cnt_q  <= '0;
      div_rem_q  <= '0;
      div_quot_q <= '0;
      step_q     <= '0;
      phase_q    <= '0;
    end else begin
      per_lat_q  <= per_lat_d;
      div_busy_q <= div_busy_d;
      div_wr_q   <= div_wr_d;
      div_cnt_q  <= div_cnt_d;
      div_rem_q  <= div_rem_d;
      div_quot_q <= div_quot_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
    end
  end

  logic [AUDIO_BIT_WIDTH-1:0] saw_w, pulse_w, tri_w;

  // Waveform shaping from the registered phase.
  always_comb begin
    saw_w   = phase_q[31 -: AUDIO_BIT_WIDTH];
    pulse_w = (phase_q[31:25] < duty_cycle) ? '1 : '0;
    tri_w   = phase_q[31] ? ~phase_q[30 -: AUDIO_BIT_WIDTH]
                          :  phase_q[30 -: AUDIO_BIT_WIDTH];
    waves   = {tri_w, pulse_w, saw_w};
  end

  // ------------------------------------------------------------------
  // Envelope: rate counter and ADSR state machine
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam int RATE_W = $clog2(128 * RATE_SCALE);
  localparam logic [ENV_WIDTH-1:0] ENV_FULL = '1;

  env_state_t           env_state_q, env_state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  logic                 env_end_q, env_end_d;
  logic [RATE_W-1:0]    rate_cnt_q, rate_cnt_d;
  logic [6:0]           stage_time;
  logic [31:0]          rate_term;
  logic                 rate_tick;
  logic [ENV_WIDTH-1:0] sus_target;

  // Rate divider terminal count for the active stage.
  always_comb begin
    case (env_state_q)
      ENV_ATTACK:  stage_time = attack_time;
      ENV_DECAY:   stage_time = decay_time;
      ENV_RELEASE: stage_time = release_time;
      default:     stage_time = 7'd0;
    endcase
    rate_term = (32'(stage_time) + 32'd1) * 32'(RATE_SCALE) - 32'd1;
    rate_tick = (32'(rate_cnt_q) == rate_term);
  end

  // ADSR next-state: note events first, then per-stage stepping.
  always_comb begin
    env_state_d = env_state_q;
    env_d       = env_q;
    rate_cnt_d  = rate_tick ? '0 : rate_cnt_q + 1'b1;
    sus_target  = ENV_WIDTH'(sustain_level) << (ENV_WIDTH - 7);
    if (note_on) begin
      env_state_d = ENV_ATTACK;
      rate_cnt_d  = '0;
    end else if (note_off && (env_state_q == ENV_ATTACK ||
                              env_state_q == ENV_DECAY  ||
                              env_state_q == ENV_SUSTAIN)) begin
      env_state_d = ENV_RELEASE;
      rate_cnt_d  = '0;
    end else begin
      case (env_state_q)
        ENV_IDLE: begin
          env_d      = '0;
          rate_cnt_d = '0;
        end
        ENV_ATTACK: begin
          if (env_q == ENV_FULL) begin
            env_state_d = ENV_DECAY;
          end else if (rate_tick) begin
            env_d = env_q + 1'b1;
            if (env_d == ENV_FULL) env_state_d = ENV_DECAY;
          end
        end
        ENV_DECAY: begin
          if (env_q <= sus_target) begin
            env_state_d = ENV_SUSTAIN;
          end else if (rate_tick) begin
            env_d = env_q - 1'b1;
            if (env_d <= sus_target) env_state_d = ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: begin
          rate_cnt_d = '0;
        end
        ENV_RELEASE: begin
          if (env_q == '0) begin
            env_state_d = ENV_IDLE;
          end else if (rate_tick) begin
            env_d = env_q - 1'b1;
            if (env_d == '0) env_state_d = ENV_IDLE;
          end
        end
        default: begin
          env_state_d = ENV_IDLE;
          env_d       = '0;
        end
      endcase
    end
    // Every stage starts its timing from a clean count.
    if (env_state_d != env_state_q) rate_cnt_d = '0;
    env_end_d = (env_state_d == ENV_IDLE);
  end

  // Envelope state registers; outputs come straight from flops.
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      env_state_q <= ENV_IDLE;
      env_q       <= '0;
      env_end_q   <= 1'b1;
      rate_cnt_q  <= '0;
    end else begin
      env_state_q <= env_state_d;
      env_q       <= env_d;
      env_end_q   <= env_end_d;
      rate_cnt_q  <= rate_cnt_d;
    end
  end

  assign envelope     = env_q;
  assign envelope_end = env_end_q;

endmodule

// File: tb/tb_voice_osc_env.sv
// Testbench for voice_osc_env: scoreboard queues hold expected waveform and
// envelope values pushed when stimulus is applied and popped at sampling.
module tb_voice_osc_env;

  localparam int PW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          note_on, note_off;
  logic [PW-1:0] period;
  logic [6:0]    duty_cycle, attack_time, decay_time, sustain_level, release_time;
  logic [47:0]   waves;
  logic [15:0]   envelope;
  logic          envelope_end;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] exp_wave_q[$];
  logic [16:0] exp_env_q[$];

  longint unsigned step_1000;

  voice_osc_env #(
    .PERIOD_WIDTH(PW),
    .AUDIO_BIT_WIDTH(16),
    .ENV_WIDTH(16),
    .RATE_SCALE(1),
    .PERIOD_MIN(2)
  ) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .note_on(note_on),
    .note_off(note_off),
    .period(period),
    .duty_cycle(duty_cycle),
    .attack_time(attack_time),
    .decay_time(decay_time),
    .sustain_level(sustain_level),
    .release_time(release_time),
    .waves(waves),
    .envelope(envelope),
    .envelope_end(envelope_end)
  );

  always #10 clk = ~clk;

  // Reference waveform for a given 32-bit phase, written arithmetically.
  function automatic logic [47:0] wave_model(input longint unsigned ph, input int duty);
    longint unsigned t;
    logic [15:0] saw, pul, tri_v;
    saw   = 16'(ph / 65536);
    pul   = ((ph / 33554432) < longint'(duty)) ? 16'hFFFF : 16'h0000;
    t     = (ph / 32768) % 65536;
    tri_v = (ph < 64'h8000_0000) ? 16'(t) : 16'(65535 - t);
    return {tri_v, pul, saw};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply an optional note event pulse (1 on, 2 off, 3 both) then idle.
  task automatic drive_env(input int ev, input int n);
    if (ev != 0) begin
      note_on  = (ev == 1 || ev == 3);
      note_off = (ev == 2 || ev == 3);
      tick(1);
      note_on  = 1'b0;
      note_off = 1'b0;
      if (n > 1) tick(n - 1);
    end else begin
      tick(n);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] ew;
    logic [16:0] ee;
    reset = 1'b1;
    note_on = 1'b0; note_off = 1'b0;
    period = PW'(1000); duty_cycle = 7'd64;
    attack_time = 7'd0; decay_time = 7'd0; sustain_level = 7'd64; release_time = 7'd0;
    exp_wave_q.push_back({16'h0000, 16'hFFFF, 16'h0000});
    exp_env_q.push_back({1'b1, 16'd0});
    tick(2);
    ew = exp_wave_q.pop_front();
    n_checks++;
    if (waves !== ew) begin
      n_fail++;
      $display("FAIL reset_waves: got %h want %h", waves, ew);
    end else $display("reset waves=%h", waves);
    ee = exp_env_q.pop_front();
    n_checks++;
    if ({envelope_end, envelope} !== ee) begin
      n_fail++;
      $display("FAIL reset_env: got end=%0b env=%0d want end=%0b env=%0d",
               envelope_end, envelope, ee[16], ee[15:0]);
    end else $display("reset end=%0b env=%0d", envelope_end, envelope);
    reset = 1'b0;
  endtask

  task automatic test_osc();
    int pts[6];
    int k_prev;
    logic [47:0] ew;
    pts = '{0, 1, 500, 501, 1000, 1001};
    step_1000 = 64'h1_0000_0000 / 1000;
    tick(34);
    k_prev = 0;
    for (int i = 0; i < 6; i++) begin
      exp_wave_q.push_back(wave_model((longint'(pts[i]) * step_1000) & 64'hFFFF_FFFF, 64));
      if (pts[i] > k_prev) tick(pts[i] - k_prev);
      k_prev = pts[i];
      ew = exp_wave_q.pop_front();
      n_checks++;
      if (waves !== ew) begin
        n_fail++;
        $display("FAIL osc_k%0d: got %h want %h", pts[i], waves, ew);
      end else $display("osc k=%0d waves=%h", pts[i], waves);
    end
  endtask

  task automatic test_restart();
    logic [47:0] ew;
    exp_wave_q.push_back(wave_model(64'd0, 64));
    drive_env(1, 1);
    ew = exp_wave_q.pop_front();
    n_checks++;
    if (waves !== ew) begin
      n_fail++;
      $display("FAIL restart_zero: got %h want %h", waves, ew);
    end else $display("restart waves=%h", waves);
    exp_wave_q.push_back(wave_model(step_1000, 64));
    tick(1);
    ew = exp_wave_q.pop_front();
    n_checks++;
    if (waves !== ew) begin
      n_fail++;
      $display("FAIL restart_step: got %h want %h", waves, ew);
    end else $display("restart+1 waves=%h", waves);
  endtask

  // period=0 clamps to 2 (step 2^31); old step stays in use for 34 clocks.
  task automatic test_period_min();
    longint unsigned base;
    int waits[3];
    logic [47:0] ew;
    waits = '{33, 1, 1};
    base = (33 * step_1000) & 64'hFFFF_FFFF;
    period = '0;
    drive_env(1, 1);
    exp_wave_q.push_back(wave_model(base, 64));
    exp_wave_q.push_back(wave_model((base + 64'h8000_0000) & 64'hFFFF_FFFF, 64));
    exp_wave_q.push_back(wave_model(base, 64));
    for (int i = 0; i < 3; i++) begin
      tick(waits[i]);
      ew = exp_wave_q.pop_front();
      n_checks++;
      if (waves !== ew) begin
        n_fail++;
        $display("FAIL pmin[%0d]: got %h want %h", i, waves, ew);
      end else $display("pmin[%0d] waves=%h", i, waves);
    end
  endtask

  task automatic test_reset_midop();
    logic [16:0] ee;
    exp_env_q.push_back({1'b0, 16'd36});
    exp_env_q.push_back({1'b1, 16'd0});
    ee = exp_env_q.pop_front();
    n_checks++;
    if ({envelope_end, envelope} !== ee) begin
      n_fail++;
      $display("FAIL midop_pre: got end=%0b env=%0d want end=%0b env=%0d",
               envelope_end, envelope, ee[16], ee[15:0]);
    end else $display("midop pre end=%0b env=%0d", envelope_end, envelope);
    reset = 1'b1;
    #2;
    ee = exp_env_q.pop_front();
    n_checks++;
    if ({envelope_end, envelope, waves[15:0]} !== {ee, 16'h0000}) begin
      n_fail++;
      $display("FAIL midop_reset: got end=%0b env=%0d saw=%h want end=%0b env=%0d saw=0",
               envelope_end, envelope, waves[15:0], ee[16], ee[15:0]);
    end else $display("midop reset end=%0b env=%0d", envelope_end, envelope);
    tick(1);
    reset = 1'b0;
    period = PW'(1000);
  endtask

  task automatic run_env_rows(input string tag, input int rows[][4]);
    logic [16:0] ee;
    for (int i = 0; i < rows.size(); i++) begin
      exp_env_q.push_back({rows[i][2] != 0, 16'(rows[i][3])});
      drive_env(rows[i][0], rows[i][1]);
      ee = exp_env_q.pop_front();
      n_checks++;
      if ({envelope_end, envelope} !== ee) begin
        n_fail++;
        $display("FAIL %s[%0d]: got end=%0b env=%0d want end=%0b env=%0d",
                 tag, i, envelope_end, envelope, ee[16], ee[15:0]);
      end else $display("%s[%0d] end=%0b env=%0d", tag, i, envelope_end, envelope);
    end
  endtask

  task automatic test_events();
    int r1[][4];
    int r2[][4];
    r1 = '{'{2, 1, 1, 0}, '{3, 1, 0, 0}, '{0, 10, 0, 10}};
    r2 = '{'{0, 3, 0, 10}, '{0, 1, 0, 11}, '{0, 4, 0, 12}};
    run_env_rows("events", r1);
    attack_time = 7'd3;
    run_env_rows("atk3", r2);
    attack_time = 7'd0;
    pulse_reset();
  endtask

  task automatic test_adsr();
    int r[][4];
    sustain_level = 7'd127;
    r = '{'{1, 1, 0, 0}, '{0, 65534, 0, 65534}, '{0, 1, 0, 65535},
          '{0, 1, 0, 65534}, '{0, 510, 0, 65024}, '{0, 50, 0, 65024},
          '{2, 1, 0, 65024}, '{0, 24, 0, 65000}};
    run_env_rows("adsr", r);
    sustain_level = 7'd64;
    pulse_reset();
  endtask

  task automatic test_retrigger();
    int r[][4];
    r = '{'{1, 1, 0, 0}, '{0, 1500, 0, 1500}, '{2, 1, 0, 1500},
          '{0, 500, 0, 1000}, '{1, 1, 0, 1000}, '{0, 1, 0, 1001},
          '{0, 9, 0, 1010}, '{2, 1, 0, 1010}, '{0, 1009, 0, 1},
          '{0, 1, 1, 0}, '{0, 5, 1, 0}};
    run_env_rows("retrig", r);
  endtask

  initial begin
    test_reset();
    test_osc();
    test_restart();
    test_period_min();
    test_reset_midop();
    test_events();
    test_adsr();
    test_retrigger();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
